// File: rtl/alu_div_pkg.sv
// alu_pkg: definitions shared between alu and alu_div.
//   OP_DIV / OP_SUB : opcode values. They reuse the multiply/add codes of alu,
//                     so one opcode field can steer both blocks.
//   state_t         : sequencer states of alu_div.
package alu_pkg;

    localparam logic [1:0] OP_DIV = 2'd2;
    localparam logic [1:0] OP_SUB = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_div_if.sv
// alu_div_if: request/response bundle for alu_div.
//   start, operation, A_hi, A_lo, B        : request (master -> slave)
//   busy, done, Q, R, overflow, div_by_zero : response (slave -> master)
// The W parameter must match the W of the alu_div instance it connects to.
interface alu_div_if #(
    parameter int W = 512
);
    logic         start;
    logic [1:0]   operation;
    logic [W-1:0] A_hi;
    logic [W-1:0] A_lo;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         overflow;
    logic         div_by_zero;

    modport master (
        output start, operation, A_hi, A_lo, B,
        input  busy, done, Q, R, overflow, div_by_zero
    );

    modport slave (
        input  start, operation, A_hi, A_lo, B,
        output busy, done, Q, R, overflow, div_by_zero
    );
endinterface

// File: rtl/alu_div_step.sv
// div_step: one combinational restoring-division step.
//   rem_in  : partial remainder (W+1 bits)
//   dsr     : divisor magnitude (W bits)
//   bit_in  : next dividend bit, shifted in at the bottom
//   rem_out : updated partial remainder
//   q_bit   : quotient bit produced by this step
module div_step #(
    parameter int W = 512
) (
    input  logic [W:0]   rem_in,
    input  logic [W-1:0] dsr,
    input  logic         bit_in,
    output logic [W:0]   rem_out,
    output logic         q_bit
);

    logic [W:0] shifted;
    logic [W:0] diff;

    assign shifted = {rem_in[W-1:0], bit_in};
    assign diff    = shifted - {1'b0, dsr};

    // The bit shifted out of the top is bit W+1 of the shifted value; if it
    // is set the value certainly exceeds the divisor and the subtraction
    // wraps back to the correct W+1-bit result.
    assign q_bit   = rem_in[W] | (shifted >= {1'b0, dsr});
    assign rem_out = q_bit ? diff : shifted;

endmodule

// File: rtl/alu_div.sv
// alu_div: sequential signed divide / subtract unit (inverse of alu).
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset
//   bus : alu_div_if.slave
//         op 2: {A_hi,A_lo} / B  -> Q quotient (toward zero), R remainder
//         op 3: sext(A_lo) - sext(B) as 2W bits -> {R,Q}
//         op 0/1: null op, Q = R = 0
// A divide takes one restoring step per cycle over 2W cycles, then one cycle
// to apply signs; done pulses for one cycle when Q/R/flags are updated.
// Short ops (subtract, null, divide by zero) complete on the start edge.
// A new start is taken in IDLE and also in DONE, so requests can be issued
// back to back on the edge after done.
module alu_div
    import alu_pkg::*;
#(
    parameter int W = 512
) (
    input  logic      clk,
    input  logic      rst,
    alu_div_if.slave  bus
);

    localparam int CW = $clog2(2 * W) + 1;

    state_t state_reg, state_next;

    logic [2*W-1:0] dq_reg;      // dividend bits shift out, quotient bits shift in
    logic [W:0]     rem_reg;
    logic [W-1:0]   dsr_reg;     // divisor magnitude
    logic           neg_q_reg;
    logic           neg_r_reg;
    logic [CW-1:0]  cnt_reg;

    logic [W-1:0]   q_reg;
    logic [W-1:0]   r_reg;
    logic           ovf_reg;
    logic           dz_reg;
    logic           done_reg;

    logic [2*W-1:0] dividend;
    logic [2*W-1:0] a_mag;
    logic [W-1:0]   b_mag;
    logic           a_neg;
    logic           b_neg;
    logic           is_div;
    logic           b_zero;
    logic           accept;
    logic           launch_div;
    logic           launch_short;
    logic [2*W-1:0] sub_diff;

    logic [W:0]     step_rem;
    logic           step_q;

    logic [2*W-1:0] q_signed;
    logic [2*W-1:0] q_lim;
    logic           q_ovf;
    logic [W-1:0]   r_signed;

    // ---------------- request decode ----------------
    assign dividend = {bus.A_hi, bus.A_lo};
    assign a_neg    = bus.A_hi[W-1];
    assign b_neg    = bus.B[W-1];
    // The most negative values map to 2^(2W-1) / 2^(W-1), which still fit
    // as unsigned magnitudes of the same width.
    assign a_mag    = a_neg ? -dividend : dividend;
    assign b_mag    = b_neg ? -bus.B : bus.B;
    assign is_div   = (bus.operation == OP_DIV);
    assign b_zero   = (bus.B == '0);

    assign accept       = bus.start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign launch_div   = accept && is_div && !b_zero;
    assign launch_short = accept && !launch_div;

    assign sub_diff = {{W{bus.A_lo[W-1]}}, bus.A_lo} - {{W{bus.B[W-1]}}, bus.B};

    // ---------------- iteration datapath ----------------
    div_step #(.W(W)) u_step (
        .rem_in  (rem_reg),
        .dsr     (dsr_reg),
        .bit_in  (dq_reg[2*W-1]),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // Sign fix-up. The quotient limit is 2^(W-1) for a negative result and
    // 2^(W-1)-1 for a positive one; Q keeps the low W bits either way.
    assign q_signed = neg_q_reg ? -dq_reg : dq_reg;
    assign q_lim    = ((2*W)'(1) << (W - 1)) - {{(2*W-1){1'b0}}, ~neg_q_reg};
    assign q_ovf    = dq_reg > q_lim;
    // The final remainder is below |B| <= 2^(W-1), so bit W is always clear.
    assign r_signed = neg_r_reg ? -rem_reg[W-1:0] : rem_reg[W-1:0];

    // ---------------- sequencer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (launch_div) begin
                    state_next = ST_DIV;
                end else if (launch_short) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (cnt_reg == CW'(2 * W - 1)) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX:  state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- datapath and result registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            dq_reg    <= '0;
            rem_reg   <= '0;
            dsr_reg   <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            cnt_reg   <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            ovf_reg   <= 1'b0;
            dz_reg    <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (launch_div) begin
                dq_reg    <= a_mag;
                rem_reg   <= '0;
                dsr_reg   <= b_mag;
                neg_q_reg <= a_neg ^ b_neg;
                neg_r_reg <= a_neg;
                cnt_reg   <= '0;
            end else if (launch_short) begin
                done_reg <= 1'b1;
                ovf_reg  <= 1'b0;
                if (is_div) begin
                    // only reachable with B == 0
                    q_reg  <= '0;
                    r_reg  <= '0;
                    dz_reg <= 1'b1;
                end else if (bus.operation == OP_SUB) begin
                    q_reg  <= sub_diff[W-1:0];
                    r_reg  <= sub_diff[2*W-1:W];
                    dz_reg <= 1'b0;
                end else begin
                    q_reg  <= '0;
                    r_reg  <= '0;
                    dz_reg <= 1'b0;
                end
            end else if (state_reg == ST_DIV) begin
                dq_reg  <= {dq_reg[2*W-2:0], step_q};
                rem_reg <= step_rem;
                cnt_reg <= cnt_reg + CW'(1);
            end else if (state_reg == ST_FIX) begin
                q_reg    <= q_signed[W-1:0];
                r_reg    <= r_signed;
                ovf_reg  <= q_ovf;
                dz_reg   <= 1'b0;
                done_reg <= 1'b1;
            end
        end
    end

    assign bus.busy        = (state_reg != ST_IDLE);
    assign bus.done        = done_reg;
    assign bus.Q           = q_reg;
    assign bus.R           = r_reg;
    assign bus.overflow    = ovf_reg;
    assign bus.div_by_zero = dz_reg;

endmodule

// File: tb/tb_alu_div.sv
// Testbench for alu_div: a W=8 instance for the directed scenarios and a
// W=512 instance for a smoke divide. A reference model computes results with
// wide signed arithmetic; a per-cycle compare process checks handshake and
// result outputs of both instances against it, and the directed vectors also
// carry hand-computed literal results and latencies.
module tb_alu_div;

    localparam int BW = 1280;
    typedef logic signed [BW-1:0] big_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_div_if #(.W(8))   b8 ();
    alu_div_if #(.W(512)) b512 ();

    alu_div #(.W(8))   u8   (.clk(clk), .rst(rst), .bus(b8));
    alu_div #(.W(512)) u512 (.clk(clk), .rst(rst), .bus(b512));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input big_t act, input big_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic big_t sx(input big_t x, input int n);
        big_t t;
        t = x << (BW - n);
        return t >>> (BW - n);
    endfunction

    function automatic big_t msk(input big_t x, input int n);
        big_t m;
        m = (big_t'(1) << n) - big_t'(1);
        return x & m;
    endfunction

    function automatic void model(input int w, input logic [1:0] op,
                                  input big_t ah, input big_t al, input big_t bb,
                                  output big_t q, output big_t r,
                                  output bit ov, output bit dz);
        big_t dvd, bs, qt, rt, lim, d;
        q = '0; r = '0; ov = 1'b0; dz = 1'b0;
        bs = sx(bb, w);
        if (op == 2'd2) begin
            dvd = sx((msk(ah, w) << w) | msk(al, w), 2 * w);
            if (bs == 0) begin
                dz = 1'b1;
            end else begin
                qt  = dvd / bs;
                rt  = dvd % bs;
                lim = big_t'(1) << (w - 1);
                ov  = (qt > lim - big_t'(1)) || (qt < -lim);
                q   = msk(qt, w);
                r   = msk(rt, w);
            end
        end else if (op == 2'd3) begin
            d = sx(al, w) - bs;
            q = msk(d, w);
            r = msk(d >>> w, w);
        end
    endfunction

    // Model state per instance: index 0 is W=8, index 1 is W=512.
    int   ww    [2] = '{8, 512};
    int   left  [2];          // edges remaining until a divide reports
    bit   mdone [2];
    big_t eq [2], er [2], pq [2], pr [2];
    bit   eo [2], ez [2], po [2], pz [2];
    bit   mvalid = 1'b0;

    task automatic mstep(input int k, input logic st, input logic [1:0] op,
                         input big_t ah, input big_t al, input big_t bb);
        bit   acc, ov, dz;
        big_t q, r;
        if (rst) begin
            left[k] = 0; mdone[k] = 1'b0;
            eq[k] = '0; er[k] = '0; eo[k] = 1'b0; ez[k] = 1'b0;
        end else begin
            acc = st && (left[k] == 0);
            mdone[k] = 1'b0;
            if (left[k] > 0) begin
                left[k]--;
                if (left[k] == 0) begin
                    eq[k] = pq[k]; er[k] = pr[k]; eo[k] = po[k]; ez[k] = pz[k];
                    mdone[k] = 1'b1;
                end
            end
            if (acc) begin
                model(ww[k], op, ah, al, bb, q, r, ov, dz);
                if (op == 2'd2 && !dz) begin
                    left[k] = 2 * ww[k] + 1;
                    pq[k] = q; pr[k] = r; po[k] = ov; pz[k] = dz;
                end else begin
                    eq[k] = q; er[k] = r; eo[k] = ov; ez[k] = dz;
                    mdone[k] = 1'b1;
                end
            end
        end
    endtask

    always begin
        big_t ah, al, bb;
        @(posedge clk);
        ah = '0; al = '0; bb = '0;
        ah[7:0] = b8.A_hi; al[7:0] = b8.A_lo; bb[7:0] = b8.B;
        mstep(0, b8.start, b8.operation, ah, al, bb);
        ah = '0; al = '0; bb = '0;
        ah[511:0] = b512.A_hi; al[511:0] = b512.A_lo; bb[511:0] = b512.B;
        mstep(1, b512.start, b512.operation, ah, al, bb);
        if (rst) mvalid = 1'b1;
    end

    // ---------------- per-cycle compare ----------------
    always begin
        big_t aq, ar;
        logic abusy, adone, ao, az;
        @(negedge clk);
        if (mvalid) begin
            for (int k = 0; k < 2; k++) begin
                aq = '0; ar = '0;
                if (k == 0) begin
                    abusy = b8.busy; adone = b8.done; ao = b8.overflow; az = b8.div_by_zero;
                    aq[7:0] = b8.Q; ar[7:0] = b8.R;
                end else begin
                    abusy = b512.busy; adone = b512.done; ao = b512.overflow; az = b512.div_by_zero;
                    aq[511:0] = b512.Q; ar[511:0] = b512.R;
                end
                chk($sformatf("w%0d busy", ww[k]), big_t'(abusy), big_t'(left[k] > 0 || mdone[k]));
                chk($sformatf("w%0d done", ww[k]), big_t'(adone), big_t'(mdone[k]));
                if (left[k] == 0) begin
                    chk($sformatf("w%0d Q", ww[k]), aq, eq[k]);
                    chk($sformatf("w%0d R", ww[k]), ar, er[k]);
                    chk($sformatf("w%0d overflow", ww[k]), big_t'(ao), big_t'(eo[k]));
                    chk($sformatf("w%0d div_by_zero", ww[k]), big_t'(az), big_t'(ez[k]));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // All tasks start and end on a falling edge.
    task automatic go8(input logic [1:0] op, input logic [7:0] ah, input logic [7:0] al,
                       input logic [7:0] bb);
        b8.operation = op; b8.A_hi = ah; b8.A_lo = al; b8.B = bb;
        b8.start = 1'b1;
        @(negedge clk);
        b8.start = 1'b0;
        // operands were captured; scrambling them must not matter
        b8.A_hi = 8'($urandom); b8.A_lo = 8'($urandom); b8.B = 8'($urandom);
    endtask

    task automatic wait8(input int n0, output int n);
        n = n0;
        while (b8.done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("w8 done seen", big_t'(b8.done), big_t'(1));
    endtask

    task automatic res8(input string nm, input logic [7:0] eqv, input logic [7:0] erv,
                        input bit eov, input bit edz, input int elat, input int n);
        chk({nm, " Q"}, b8.Q, eqv);
        chk({nm, " R"}, b8.R, erv);
        chk({nm, " overflow"}, big_t'(b8.overflow), big_t'(eov));
        chk({nm, " div_by_zero"}, big_t'(b8.div_by_zero), big_t'(edz));
        chk({nm, " latency"}, n, elat);
        $display("txn %s: Q=%h R=%h ovf=%b dz=%b latency=%0d", nm, b8.Q, b8.R,
                 b8.overflow, b8.div_by_zero, n);
    endtask

    task automatic run8(input string nm, input logic [1:0] op, input logic [7:0] ah,
                        input logic [7:0] al, input logic [7:0] bb,
                        input logic [7:0] eqv, input logic [7:0] erv,
                        input bit eov, input bit edz, input int elat);
        int n;
        go8(op, ah, al, bb);
        wait8(0, n);
        res8(nm, eqv, erv, eov, edz, elat, n);
    endtask

    initial begin
        int   n;
        big_t t;
        b8.start = 1'b0; b8.operation = '0; b8.A_hi = '0; b8.A_lo = '0; b8.B = '0;
        b512.start = 1'b0; b512.operation = '0; b512.A_hi = '0; b512.A_lo = '0; b512.B = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset busy", big_t'(b8.busy), big_t'(0));
        chk("reset done", big_t'(b8.done), big_t'(0));
        chk("reset Q", b8.Q, 0);
        chk("reset R", b8.R, 0);

        run8("div 42/5", 2'd2, 8'h00, 8'h2A, 8'h05, 8'h08, 8'h02, 0, 0, 17);
        @(negedge clk);
        chk("done one cycle", big_t'(b8.done), big_t'(0));
        chk("idle after done", big_t'(b8.busy), big_t'(0));

        run8("div -42/5",   2'd2, 8'hFF, 8'hD6, 8'h05, 8'hF8, 8'hFE, 0, 0, 17);
        // issued on the edge right after done: back-to-back acceptance
        run8("div -42/-5",  2'd2, 8'hFF, 8'hD6, 8'hFB, 8'h08, 8'hFE, 0, 0, 17);
        run8("div 256/1",   2'd2, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 1, 0, 17);
        run8("div -128/1",  2'd2, 8'hFF, 8'h80, 8'h01, 8'h80, 8'h00, 0, 0, 17);
        run8("div 127/1",   2'd2, 8'h00, 8'h7F, 8'h01, 8'h7F, 8'h00, 0, 0, 17);
        run8("div min/-1",  2'd2, 8'h80, 8'h00, 8'hFF, 8'h00, 8'h00, 1, 0, 17);
        run8("div 32767/-128", 2'd2, 8'h7F, 8'hFF, 8'h80, 8'h01, 8'h7F, 1, 0, 17);
        run8("div by zero", 2'd2, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 0, 1, 0);
        run8("sub -8-7",    2'd3, 8'h55, 8'hF8, 8'h07, 8'hF1, 8'hFF, 0, 0, 0);
        run8("sub 127+128", 2'd3, 8'h00, 8'h7F, 8'h80, 8'hFF, 8'h00, 0, 0, 0);
        run8("null op1",    2'd1, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 0, 0, 0);
        run8("null op0",    2'd0, 8'h9A, 8'hBC, 8'hDE, 8'h00, 8'h00, 0, 0, 0);
        @(negedge clk);

        // start pulsed at edge 5 of a divide must be ignored
        go8(2'd2, 8'h00, 8'h2A, 8'h05);
        repeat (4) @(negedge clk);
        b8.operation = 2'd3; b8.A_hi = 8'h00; b8.A_lo = 8'h11; b8.B = 8'h22;
        b8.start = 1'b1;
        @(negedge clk);
        b8.start = 1'b0;
        wait8(5, n);
        res8("ignored start", 8'h08, 8'h02, 0, 0, 17, n);
        @(negedge clk);

        // reset sampled at edge 6 of a divide
        go8(2'd2, 8'h00, 8'h2A, 8'h05);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid-div rst busy", big_t'(b8.busy), big_t'(0));
        chk("mid-div rst done", big_t'(b8.done), big_t'(0));
        chk("mid-div rst Q", b8.Q, 0);
        chk("mid-div rst R", b8.R, 0);
        $display("txn reset mid-div: busy=%b Q=%h R=%h", b8.busy, b8.Q, b8.R);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("no done after rst", big_t'(b8.done), big_t'(0));
        end
        run8("div 42/5 after rst", 2'd2, 8'h00, 8'h2A, 8'h05, 8'h08, 8'h02, 0, 0, 17);
        @(negedge clk);

        // W=512 smoke: -1000 / 7 = -142 rem -6
        t = -1000;
        b512.operation = 2'd2; b512.A_hi = '1; b512.A_lo = t[511:0]; b512.B = 512'd7;
        b512.start = 1'b1;
        @(negedge clk);
        b512.start = 1'b0;
        b512.A_lo = '0; b512.B = '0;
        n = 0;
        while (b512.done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("w512 done seen", big_t'(b512.done), big_t'(1));
        t = '0; t[511:0] = b512.Q;
        chk("w512 Q", t, msk(-142, 512));
        t = '0; t[511:0] = b512.R;
        chk("w512 R", t, msk(-6, 512));
        chk("w512 overflow", big_t'(b512.overflow), big_t'(0));
        chk("w512 latency", n, 1025);
        $display("txn w512 div -1000/7: latency=%0d Q[15:0]=%h R[15:0]=%h", n,
                 b512.Q[15:0], b512.R[15:0]);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
